spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
- Upstream neighbour of the single-port RAM. Terminates the SPI bus (mode 0, MSB first, SCK used directly as clk).
- Deserialises 10-bit command frames from mosi into rx_data with a one-cycle rx_valid pulse.
- For read-data frames, captures the RAM's tx_data on tx_valid and serialises 8 bits back on miso.
- Command encoding in rx_data[9:8]: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data.

Parameters:
- FRAME_W, 10, bits per MOSI frame (2 command bits + 8 payload bits).
- DATA_W, 8, bits of read data shifted out on miso.

Ports:
- clk  in  1  SPI clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ss_n  in  1  slave select, active-low.
- mosi  in  1  serial data in, sampled on rising clk.
- miso  out  1  serial data out, registered.
- rx_data  out  FRAME_W  assembled frame to RAM (din).
- rx_valid  out  1  one-cycle strobe, rx_data valid.
- tx_data  in  DATA_W  read data from RAM (dout).
- tx_valid  in  1  tx_data valid strobe from RAM.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; rx_data=0; rx_valid=0; miso=0.
  - bit counter=0; rd_addr_received=0.
  - Reset overrides all other inputs, including mid-frame.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: ss_n=0 at edge k -> CHK_CMD. ss_n=1 -> stay.
- CHK_CMD, edge k+1: mosi is frame bit 9 (stored in shift reg). Next state:
  - mosi=0 -> WRITE.
  - mosi=1 and rd_addr_received=0 -> READ_ADD.
  - mosi=1 and rd_addr_received=1 -> READ_DATA.
- Frame receive:
  - Edges k+2..k+10 shift bits 8..0 MSB first.
  - At edge k+10, rx_data <= full 10-bit frame and rx_valid=1 for exactly that one cycle.
  - rx_data holds its value until the next frame completes.
- After a complete frame:
  - WRITE and READ_ADD ignore further mosi until ss_n=1.
  - READ_ADD completion sets rd_addr_received=1.
  - READ_DATA completion clears rd_addr_received=0.
- rx_data is forwarded verbatim. Bit 8 is not checked; the state decision uses bit 9 and rd_addr_received only.
- READ_DATA output phase:
  - After its rx_valid pulse, wait for tx_valid=1. At that edge, load tx_data into the tx shift register.
  - miso carries tx_data[7] in the following cycle, then [6]..[0] on subsequent cycles (8 cycles total), then returns to 0.
  - tx_valid outside this wait window is ignored, including during shifting.
  - tx_valid in the same cycle as rx_valid is ignored; loading starts the cycle after rx_valid.
- Abort: ss_n=1 at any edge in any state ->
  - IDLE, counter=0, miso=0; rx_valid not asserted for the partial frame; rd_addr_received unchanged.
  - Abort during miso shifting truncates the output.
- Back-to-back frames: ss_n must pass through 1 for at least one edge (returns to IDLE). A new frame starts on the next ss_n=0.
- miso is 0 whenever not actively shifting.

Decomposition:
- Package spi_pkg:
  - state_e enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA).
  - CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - FRAME_W, DATA_W defaults.
- Sub-module spi_tx_shifter: DATA_W-bit parallel-load, MSB-first shift register with a 'busy' flag and bit counter; drives miso.
- FSM, rx shift register and rd_addr_received stay in spi_slave_if.

Test Plan:
- Write pair: frame 00_0000_1111, ss_n high, then frame 01_1010_0101 -> rx_valid pulses at edge k+10 of each frame with rx_data=0x00F then 0x1A5; miso stays 0.
- Read sequence: frame 10_0000_1111 (state READ_ADD, rx_data=0x20F, rd_addr_received=1), then frame 11_xxxx_xxxx (READ_DATA), tx_valid=1 with tx_data=0xA5 two cycles later -> miso = 1,0,1,0,0,1,0,1 on the 8 following cycles; rd_addr_received=0 afterwards.
- Second 1-leading frame without a prior read-addr (rd_addr_received=0) -> enters READ_ADD, not READ_DATA; tx_valid pulses ignored, miso stays 0.
- Abort: ss_n rises after 5 bits of a write frame -> no rx_valid, state IDLE next cycle; the following full frame 00_1111_0000 yields rx_data=0x0F0 correctly.
- Reset mid-shift: rst=1 while miso is shifting 0xFF -> miso=0, rx_valid=0, rd_addr_received=0 on the next cycle; a subsequent 1-leading frame enters READ_ADD.
- Stray tx_valid=1 during a WRITE frame and during READ_DATA shifting -> no reload, miso sequence unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end of the single-port RAM.
package spi_pkg;

    localparam int DEF_FRAME_W = 10;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first serialiser for read data; miso is registered and
// idles low once the last bit has been held for a cycle.
module spi_tx_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              miso,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W);

    logic [DATA_W-1:0] sreg;
    logic [CW-1:0]     cnt;

    // cnt holds the number of bits still to be presented after the current one
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sreg <= '0;
            cnt  <= '0;
            miso <= 1'b0;
            busy <= 1'b0;
        end else if (load) begin
            miso <= din[DATA_W-1];
            sreg <= {din[DATA_W-2:0], 1'b0};
            cnt  <= CW'(DATA_W - 1);
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) begin
                miso <= 1'b0;
                busy <= 1'b0;
            end else begin
                miso <= sreg[DATA_W-1];
                sreg <= {sreg[DATA_W-2:0], 1'b0};
                cnt  <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: deserialises command frames toward the RAM and, for
// read-data frames, returns one RAM byte on miso.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    state_e             state, state_nx;
    logic [FRAME_W-2:0] shift_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic               rd_addr_received;
    logic               tx_started;
    logic               tx_busy;
    logic               frame_done;
    logic               tx_load;

    assign frame_done = (bit_cnt == CNT_FULL);
    // Load window opens the cycle after the rx_valid pulse and closes after one load
    assign tx_load = !ss_n && (state == READ_DATA) && frame_done && !rx_valid
                     && !tx_started && !tx_busy && tx_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (ss_n) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = CHK_CMD;
                CHK_CMD: state_nx = !mosi ? WRITE : (rd_addr_received ? READ_DATA : READ_ADD);
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg        <= '0;
            bit_cnt          <= '0;
            rx_data          <= '0;
            rx_valid         <= 1'b0;
            rd_addr_received <= 1'b0;
            tx_started       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (ss_n) begin
                bit_cnt    <= '0;
                tx_started <= 1'b0;
            end else begin
                case (state)
                    CHK_CMD: begin
                        shift_reg  <= {shift_reg[FRAME_W-3:0], mosi};
                        bit_cnt    <= CNT_W'(1);
                        tx_started <= 1'b0;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!frame_done) begin
                            shift_reg <= {shift_reg[FRAME_W-3:0], mosi};
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == CNT_LAST) begin
                                rx_data  <= {shift_reg, mosi};
                                rx_valid <= 1'b1;
                                if (state == READ_ADD)  rd_addr_received <= 1'b1;
                                if (state == READ_DATA) rd_addr_received <= 1'b0;
                            end
                        end
                        if (tx_load) tx_started <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    spi_tx_shifter #(.DATA_W(DATA_W)) u_tx (
        .clk  (clk),
        .rst  (rst),
        .clr  (ss_n),
        .load (tx_load),
        .din  (tx_data),
        .miso (miso),
        .busy (tx_busy)
    );

endmodule

// File: tb/tb_spi_slave_if.sv
// Session-level bench: each vector is one ss_n-low window; expected outputs
// come from a transaction model of the frame/read-back rules.
module tb_spi_slave_if;

    localparam int FW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, ss_n, mosi, miso, rx_valid, tx_valid;
    logic [FW-1:0] rx_data;
    logic [DW-1:0] tx_data;

    always #5 clk = ~clk;

    spi_slave_if #(.FRAME_W(FW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    typedef struct {
        logic [FW-1:0] frame;
        int            len;      // edges with ss_n low
        logic [31:0]   txv;      // tx_valid per session edge
        logic [DW-1:0] txd;
        int            rst_at;   // edge at which rst is raised, -1 none
        int            exp_ones; // ones seen on miso in the session, -1 unchecked
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    logic          rd_m;
    logic [FW-1:0] rx_m;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        logic cmd, rdd, complete, exp_b;
        int   load, stop, ones;
        cmd      = v.frame[FW-1];
        rdd      = cmd && rd_m;
        complete = (v.len >= 11) && (v.rst_at < 0 || v.rst_at > 10);
        stop     = (v.rst_at >= 0) ? v.rst_at : v.len;
        load     = -1;
        if (rdd && complete)
            for (int c = 12; c < stop; c++)
                if (v.txv[c] && load < 0) load = c;
        ones = 0;
        for (int c = 0; c < v.len; c++) begin
            ss_n     = 1'b0;
            rst      = (c == v.rst_at);
            mosi     = (c >= 1 && c <= 10) ? v.frame[10-c] : 1'($urandom);
            tx_valid = v.txv[c];
            tx_data  = v.txv[c] ? v.txd : 8'($urandom);
            @(posedge clk); #1;
            if (c == v.rst_at) begin
                rx_m = '0;
                chk("rst_miso", idx, 32'(miso), 32'd0);
                chk("rst_rx_valid", idx, 32'(rx_valid), 32'd0);
                chk("rst_rx_data", idx, 32'(rx_data), 32'(rx_m));
                break;
            end
            if (complete && c == 10) rx_m = v.frame;
            exp_b = (load >= 0 && c >= load && c < load + 8) ? v.txd[7-(c-load)] : 1'b0;
            chk("miso", idx, 32'(miso), 32'(exp_b));
            chk("rx_valid", idx, 32'(rx_valid), 32'(complete && c == 10));
            chk("rx_data", idx, 32'(rx_data), 32'(rx_m));
            ones += int'(miso);
        end
        if (complete) begin
            if (rdd)      rd_m = 1'b0;
            else if (cmd) rd_m = 1'b1;
        end
        if (v.rst_at >= 0 && v.rst_at < v.len) rd_m = 1'b0;
        rst  = 1'b0;
        ss_n = 1'b1;
        repeat (1 + $urandom_range(0, 1)) begin
            mosi     = 1'($urandom);
            tx_valid = 1'($urandom);
            tx_data  = 8'($urandom);
            @(posedge clk); #1;
            chk("gap_miso", idx, 32'(miso), 32'd0);
            chk("gap_rx_valid", idx, 32'(rx_valid), 32'd0);
            chk("gap_rx_data", idx, 32'(rx_data), 32'(rx_m));
        end
        if (v.exp_ones >= 0) chk("miso_ones", idx, 32'(ones), 32'(v.exp_ones));
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{10'h00F, 12, 32'h0,      8'h00, -1, 0}; // write addr
        tbl[1]  = '{10'h1A5, 12, 32'h0,      8'h00, -1, 0}; // write data
        tbl[2]  = '{10'h20F, 12, 32'h0,      8'h00, -1, 0}; // read addr
        tbl[3]  = '{10'h3C3, 24, 32'h9800,   8'hA5, -1, 4}; // read data, stray tx_valid
        tbl[4]  = '{10'h3FF, 20, 32'hFF000,  8'hFF, -1, 0}; // READ_ADD, tx_valid ignored
        tbl[5]  = '{10'h0AA, 6,  32'h0,      8'h00, -1, 0}; // abort after 5 bits
        tbl[6]  = '{10'h0F0, 12, 32'h0,      8'h00, -1, 0};
        tbl[7]  = '{10'h300, 20, 32'h800,    8'hFF, -1, 0}; // tx_valid only alongside rx_valid
        tbl[8]  = '{10'h255, 12, 32'h0,      8'h00, -1, 0};
        tbl[9]  = '{10'h300, 17, 32'h4000,   8'hFF, -1, 3}; // truncated by ss_n
        tbl[10] = '{10'h2AA, 12, 32'h0,      8'h00, -1, 0};
        tbl[11] = '{10'h3FF, 30, 32'h1000,   8'hFF, 15, 3}; // reset mid-shift
        tbl[12] = '{10'h2F0, 20, 32'h1F000,  8'hFF, -1, 0}; // READ_ADD after reset

        rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
        rd_m = 1'b0; rx_m = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_miso", -1, 32'(miso), 32'd0);
        chk("reset_rx_valid", -1, 32'(rx_valid), 32'd0);
        chk("reset_rx_data", -1, 32'(rx_data), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) run(i, tbl[i]);

        for (int i = 0; i < 60; i++) begin
            vec_t r;
            r.frame    = 10'($urandom);
            r.len      = $urandom_range(6, 30);
            r.txv      = $urandom & $urandom;
            r.txd      = 8'($urandom);
            r.rst_at   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, r.len - 1) : -1;
            r.exp_ones = -1;
            run(100 + i, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
